// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_pkg
//  Purpose  : Shared types and default sizes for the register-file write-back
//             arbiter and its LSU result FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package rf_wb_pkg;

  localparam int XLEN  = 32;  // RF write data width
  localparam int AW    = 5;   // register address width
  localparam int DEPTH = 4;   // LSU result FIFO entries (power of 2, >= 2)

  // Which source owns the RF write port in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } wb_src_e;

  // One buffered LSU result
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_fifo
//  Purpose  : Synchronous FIFO of wb_entry_t holding LSU results while the
//             ALU owns the RF write port. Head is visible combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = rf_wb_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output wb_entry_t                head
);

  localparam int IW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [IW:0] wr_ptr_q, wr_ptr_d;
  logic [IW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];

  // Pointer advance on push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared on reset (drops all buffered entries)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[IW-1:0]] <= din;
  end

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (level == (IW+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q[IW-1:0]];

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Write-back stage in front of the register file. Merges ALU and
//             LSU results onto one registered write port, buffers LSU results
//             that lose arbitration, and tracks registers with outstanding LSU
//             writes so decode can stall.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  // Must match the package defaults, which size wb_entry_t
  parameter int XLEN  = rf_wb_pkg::XLEN,
  parameter int AW    = rf_wb_pkg::AW,
  parameter int DEPTH = rf_wb_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_we,
  input  logic [AW-1:0]           alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [AW-1:0]           lsu_rd,
  input  logic [XLEN-1:0]         lsu_data,
  input  logic                    sb_set,
  input  logic [AW-1:0]           sb_rd,
  input  logic [AW-1:0]           q_add1,
  input  logic [AW-1:0]           q_add2,
  output logic                    busy1,
  output logic                    busy2,
  output logic                    wb_we,
  output logic [AW-1:0]           wb_add,
  output logic [XLEN-1:0]         wb_data,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int NREG = 1 << AW;

  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t   fifo_head, lsu_entry;
  wb_src_e     src;
  logic        alu_live, lsu_live;

  logic            wb_we_q,   wb_we_d;
  logic [AW-1:0]   wb_add_q,  wb_add_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            lsu_wb_q,  lsu_wb_d;   // last registered write came from LSU
  logic [NREG-1:0] pending_q, pending_d;

  // Ready depends only on registered occupancy, never on lsu_valid
  assign lsu_ready = !fifo_full;
  assign alu_live  = alu_we && (alu_rd != '0);
  // A transfer to x0 is consumed but never written or buffered
  assign lsu_live  = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  // Port arbitration: ALU, then FIFO head, then direct LSU bypass
  always_comb begin
    src = SRC_NONE;
    if (alu_live)         src = SRC_ALU;
    else if (!fifo_empty) src = SRC_FIFO;
    else if (lsu_live)    src = SRC_BYP;
  end

  assign fifo_pop  = (src == SRC_FIFO);
  assign fifo_push = lsu_live && (src != SRC_BYP);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (lsu_entry),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .head  (fifo_head)
  );

  // Write-port next state; address and data hold when nothing is selected
  always_comb begin
    wb_we_d   = 1'b0;
    wb_add_d  = wb_add_q;
    wb_data_d = wb_data_q;
    lsu_wb_d  = 1'b0;
    case (src)
      SRC_ALU: begin
        wb_we_d = 1'b1; wb_add_d = alu_rd; wb_data_d = alu_data;
      end
      SRC_FIFO: begin
        wb_we_d = 1'b1; wb_add_d = fifo_head.rd; wb_data_d = fifo_head.data;
        lsu_wb_d = 1'b1;
      end
      SRC_BYP: begin
        wb_we_d = 1'b1; wb_add_d = lsu_rd; wb_data_d = lsu_data;
        lsu_wb_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Pending vector: an LSU write clears its bit one edge after it appears on
  // the port; a same-cycle set on that register wins; x0 is never pending
  always_comb begin
    pending_d = pending_q;
    if (lsu_wb_q) pending_d[wb_add_q] = 1'b0;
    if (sb_set)   pending_d[sb_rd]    = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_add_q  <= '0;
      wb_data_q <= '0;
      lsu_wb_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_add_q  <= wb_add_d;
      wb_data_q <= wb_data_d;
      lsu_wb_q  <= lsu_wb_d;
      pending_q <= pending_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_add  = wb_add_q;
  assign wb_data = wb_data_q;
  assign busy1   = pending_q[q_add1];
  assign busy2   = pending_q[q_add2];

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Purpose  : Self-checking bench for rf_wb_arbiter: directed scenarios then
//             random traffic, checked against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_we = 1'b0, lsu_valid = 1'b0, sb_set = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, sb_rd = '0, q_add1 = '0, q_add2 = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        lsu_ready, busy1, busy2, wb_we;
  logic [4:0]  wb_add;
  logic [31:0] wb_data;
  logic [2:0]  fifo_level;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .sb_set(sb_set), .sb_rd(sb_rd), .q_add1(q_add1), .q_add2(q_add2),
    .busy1(busy1), .busy2(busy2),
    .wb_we(wb_we), .wb_add(wb_add), .wb_data(wb_data), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t        mq[$];    // LSU results waiting for the port
  ent_t        expq[$];  // RF writes expected on the next cycle
  logic [31:0] pend = '0;
  logic [4:0]  hold_add = '0;
  logic [31:0] hold_data = '0;
  bit          armed = 0;
  bit          last_lsu = 0;
  logic [4:0]  last_add = '0;

  bit   m_xfer, m_live, m_byp, m_lsu, m_wr;
  ent_t m_w;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); expq.delete();
      pend = '0; hold_add = '0; hold_data = '0;
      last_lsu = 0; armed = 1;
    end else if (armed) begin
      m_xfer = lsu_valid && (mq.size() < DEPTH);
      m_live = m_xfer && (lsu_rd != 0);
      m_byp = 0; m_lsu = 0; m_wr = 0; m_w = '0;
      if (last_lsu) pend[last_add] = 1'b0;
      if (sb_set && sb_rd != 0) pend[sb_rd] = 1'b1;
      if (alu_we && alu_rd != 0) begin
        m_w = '{alu_rd, alu_data}; m_wr = 1;
      end else if (mq.size() > 0) begin
        m_w = mq.pop_front(); m_wr = 1; m_lsu = 1;
      end else if (m_live) begin
        m_w = '{lsu_rd, lsu_data}; m_wr = 1; m_lsu = 1; m_byp = 1;
      end
      if (m_live && !m_byp) mq.push_back('{lsu_rd, lsu_data});
      if (m_wr) begin
        expq.push_back(m_w);
        hold_add = m_w.rd; hold_data = m_w.data;
      end
      last_lsu = m_lsu;
      last_add = m_w.rd;
    end
  end

  // ---------------- monitor ----------------
  ent_t got;
  always @(negedge clk) begin
    if (armed && !rst) begin
      if (wb_we === 1'b1) begin
        if (expq.size() == 0) begin
          chk("wb_unexpected", {27'd0, wb_add}, 32'hFFFF_FFFF);
        end else begin
          got = expq.pop_front();
          chk("wb_add", {27'd0, wb_add}, {27'd0, got.rd});
          chk("wb_data", wb_data, got.data);
        end
      end else begin
        if (expq.size() != 0) begin
          got = expq.pop_front();
          chk("wb_missing", {31'd0, wb_we}, 32'd1);
        end
        chk("wb_add_hold", {27'd0, wb_add}, {27'd0, hold_add});
        chk("wb_data_hold", wb_data, hold_data);
      end
      chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, (mq.size() < DEPTH)});
      chk("fifo_level", {29'd0, fifo_level}, mq.size());
      chk("busy1", {31'd0, busy1}, {31'd0, pend[q_add1]});
      chk("busy2", {31'd0, busy2}, {31'd0, pend[q_add2]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_we = 0; lsu_valid = 0; sb_set = 0;
  endtask

  initial begin
    int k;
    bit acc;
    step(); step();
    rst = 0;

    // ALU only, then ALU to x0
    alu_we = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; step();
    alu_rd = 0; alu_data = 32'h12345678; step();
    idle(); step();

    // Direct bypass
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11; step();
    idle(); step();

    // Contention
    alu_we = 1; alu_rd = 3; alu_data = 32'h333;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h444; step();
    idle(); step(); step();

    // Fill and backpressure
    k = 0;
    for (int i = 0; i < 6; i++) begin
      alu_we = 1; alu_rd = 5'(20 + i); alu_data = 32'hA000 + i;
      lsu_valid = (k < 4); lsu_rd = 5'(8 + k); lsu_data = 32'h800 + k;
      acc = lsu_valid && lsu_ready;
      step();
      if (acc) k++;
    end
    idle(); repeat (6) step();

    // LSU result to x0 is consumed silently
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hBAD; step();
    idle(); step();

    // Scoreboard set, clear, and set-wins
    q_add1 = 9; q_add2 = 10;
    sb_set = 1; sb_rd = 9; step();
    sb_set = 0; step();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99; step();
    lsu_valid = 0; sb_set = 1; sb_rd = 9; step();
    sb_set = 0; step(); step();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h98; step();
    idle(); step(); step(); step();

    // Reset mid-operation with buffered entries and pending registers
    q_add1 = 8; q_add2 = 9;
    sb_set = 1; sb_rd = 8; step();
    sb_rd = 9; step();
    sb_set = 0;
    for (int i = 0; i < 3; i++) begin
      alu_we = 1; alu_rd = 5'(1 + i); alu_data = 32'hC0 + i;
      lsu_valid = 1; lsu_rd = 5'(12 + i); lsu_data = 32'hE0 + i;
      step();
    end
    idle(); rst = 1; step();
    rst = 0; repeat (5) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      alu_we    = ($urandom_range(0, 2) != 0);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 1) != 0);
      lsu_rd    = 5'($urandom_range(0, 31));
      lsu_data  = $urandom;
      sb_set    = ($urandom_range(0, 3) == 0);
      sb_rd     = 5'($urandom_range(0, 31));
      q_add1    = 5'($urandom_range(0, 31));
      q_add2    = 5'($urandom_range(0, 31));
      step();
    end
    rst = 0; idle(); repeat (10) step();

    chk("expected_queue_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
